// File: rtl/i2c_slave_regbank_if.sv
// Parallel byte bus between i2c_slave_serializer (master side) and the
// register-bank controller (slave side).
interface i2c_slave_regbank_if #(
   parameter int NUM_REGS = 4
);
   logic                    start;
   logic                    stop;
   logic                    wr;
   logic [7:0]              write_data;
   logic                    wr_ack;
   logic [NUM_REGS*8-1:0]   regs;
   logic [NUM_REGS-1:0]     update;
   logic                    busy;

   modport master (
      output start, stop, wr, write_data,
      input  wr_ack, regs, update, busy
   );

   modport slave (
      input  start, stop, wr, write_data,
      output wr_ack, regs, update, busy
   );
endinterface

// File: rtl/i2c_slave_regbank.sv
// I2C register-bank controller: address byte, index byte, then
// auto-incrementing data bytes staged in shadow registers. Staged bytes
// become visible on regs (with one-cycle update strobes) only on STOP.
module i2c_slave_regbank #(
   parameter logic [6:0]            I2C_ADDRESS = 7'h00,
   parameter int                    NUM_REGS    = 4,
   parameter int                    INDEX_WIDTH = 2,
   parameter logic [NUM_REGS*8-1:0] RESET_VALUE = '0
) (
   input logic                clk,
   input logic                reset_n,
   i2c_slave_regbank_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_INDEX,
      S_DATA,
      S_DISCARD
   } state_t;

   state_t                   state_q;
   logic [INDEX_WIDTH-1:0]   ptr_q;
   logic [7:0]               shadow_q [NUM_REGS];
   logic [NUM_REGS-1:0]      dirty_q;
   logic [NUM_REGS*8-1:0]    regs_q;
   logic [NUM_REGS-1:0]      update_q;
   logic                     wr_ack_q;
   logic                     busy_q;

   // All outputs come straight from registers.
   assign bus.regs   = regs_q;
   assign bus.update = update_q;
   assign bus.wr_ack = wr_ack_q;
   assign bus.busy   = busy_q;

   // Transaction FSM: STOP is handled first (commit), then START overrides
   // the next state, otherwise a byte strobe is decoded by state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         dirty_q  <= '0;
         regs_q   <= RESET_VALUE;
         update_q <= '0;
         wr_ack_q <= 1'b0;
         busy_q   <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow_q[i] <= RESET_VALUE[8*i +: 8];
         end
      end else begin
         update_q <= '0;

         if (bus.stop) begin
            case (state_q)
               S_ADDR: begin
                  // STOP right after a (repeated) START: drop staged data.
                  dirty_q <= '0;
                  busy_q  <= 1'b0;
               end
               S_INDEX, S_DATA, S_DISCARD: begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (dirty_q[i]) begin
                        regs_q[8*i +: 8] <= shadow_q[i];
                        update_q[i]      <= 1'b1;
                     end
                  end
                  dirty_q <= '0;
                  busy_q  <= 1'b0;
               end
               default: ;
            endcase
            state_q <= S_IDLE;
         end

         if (bus.start) begin
            state_q <= S_ADDR;
         end else if (bus.wr && !bus.stop) begin
            case (state_q)
               S_ADDR: begin
                  if (bus.write_data[7:1] == I2C_ADDRESS && !bus.write_data[0]) begin
                     wr_ack_q <= 1'b1;
                     busy_q   <= 1'b1;
                     state_q  <= S_INDEX;
                  end else begin
                     // Not addressed as a writer: abandon anything staged
                     // so it cannot leak into a later transaction's commit.
                     wr_ack_q <= 1'b0;
                     busy_q   <= 1'b0;
                     dirty_q  <= '0;
                     state_q  <= S_IDLE;
                  end
               end
               S_INDEX: begin
                  if (bus.write_data < 8'(NUM_REGS)) begin
                     ptr_q    <= bus.write_data[INDEX_WIDTH-1:0];
                     wr_ack_q <= 1'b1;
                     state_q  <= S_DATA;
                  end else begin
                     wr_ack_q <= 1'b0;
                     state_q  <= S_DISCARD;
                  end
               end
               S_DATA: begin
                  shadow_q[ptr_q] <= bus.write_data;
                  dirty_q[ptr_q]  <= 1'b1;
                  wr_ack_q        <= 1'b1;
                  if (ptr_q == INDEX_WIDTH'(NUM_REGS - 1)) begin
                     ptr_q <= '0;
                  end else begin
                     ptr_q <= ptr_q + 1'b1;
                  end
               end
               S_DISCARD: begin
                  wr_ack_q <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
